// File: rtl/bc_feature_loader.sv
// Raw-feature front-end for the 7-feature ternary classifier: quantise, collect, hold.
// Optional `BC_FEATLOAD_STATS_EN adds stat_samples / stat_drops counters.
module bc_feature_loader #(
    parameter logic [7:0] T1 = 8'd64,
    parameter logic [7:0] T2 = 8'd128,
    parameter logic [7:0] T3 = 8'd192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_feat,
    output logic        frame_err
`ifdef BC_FEATLOAD_STATS_EN
    ,
    output logic [15:0] stat_samples,
    output logic [15:0] stat_drops
`endif
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [13:0] coll_q, coll_d;
    logic [13:0] hold_q, hold_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        rdy_q;

    logic [1:0]  code;
    logic        beat_acc;
    logic        drain;
    logic        copy;
    logic [13:0] copy_vec;

    always_comb begin
        if (in_data >= T3)      code = 2'd3;
        else if (in_data >= T2) code = 2'd2;
        else if (in_data >= T1) code = 2'd1;
        else                    code = 2'd0;
    end

    assign in_ready = rdy_q && (state_q != ST_FULL);
    assign beat_acc = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        coll_d      = coll_q;
        frame_err_d = 1'b0;
        copy        = 1'b0;
        copy_vec    = coll_q;

        case (state_q)
            ST_COLLECT: begin
                if (beat_acc) begin
                    coll_d[{idx_q, 1'b0} +: 2] = code;
                    if (idx_q == 3'd6) begin
                        if (in_last) begin
                            // The final code bypasses the collection so a free holding slot takes it now.
                            if (!out_valid_q || out_ready) begin
                                copy     = 1'b1;
                                copy_vec = {code, coll_q[11:0]};
                                idx_d    = 3'd0;
                            end else begin
                                state_d = ST_FULL;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            idx_d       = 3'd0;
                            state_d     = ST_DISCARD;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_FULL: begin
                if (drain) begin
                    copy     = 1'b1;
                    copy_vec = coll_q;
                    idx_d    = 3'd0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_DISCARD: begin
                if (beat_acc && in_last) begin
                    idx_d   = 3'd0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                idx_d   = 3'd0;
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        if (copy) begin
            hold_d      = copy_vec;
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= 3'd0;
            coll_q      <= 14'd0;
            hold_q      <= 14'd0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coll_q      <= coll_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            rdy_q       <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_feat  = hold_q;
    assign frame_err = frame_err_q;

`ifdef BC_FEATLOAD_STATS_EN
    logic [15:0] stat_samples_q, stat_samples_d;
    logic [15:0] stat_drops_q, stat_drops_d;

    always_comb begin
        stat_samples_d = stat_samples_q + {15'd0, copy};
        stat_drops_d   = stat_drops_q + {15'd0, frame_err_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_samples_q <= 16'd0;
            stat_drops_q   <= 16'd0;
        end else begin
            stat_samples_q <= stat_samples_d;
            stat_drops_q   <= stat_drops_d;
        end
    end

    assign stat_samples = stat_samples_q;
    assign stat_drops   = stat_drops_q;
`endif

endmodule

// File: tb/tb_bc_feature_loader.sv
// Self-checking bench for bc_feature_loader: directed frames plus random traffic
// checked cycle by cycle against a queue-based frame model.
module tb_bc_feature_loader;

    localparam logic [7:0] T1 = 8'd64;
    localparam logic [7:0] T2 = 8'd128;
    localparam logic [7:0] T3 = 8'd192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [13:0] out_feat;
    logic        frame_err;
`ifdef BC_FEATLOAD_STATS_EN
    logic [15:0] stat_samples;
    logic [15:0] stat_drops;
`endif

    bc_feature_loader #(.T1(T1), .T2(T2), .T3(T3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_feat  (out_feat),
        .frame_err (frame_err)
`ifdef BC_FEATLOAD_STATS_EN
        ,
        .stat_samples (stat_samples),
        .stat_drops   (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: codes of the frame in progress, a skip flag for an
    // over-long frame, one vector waiting for the holding slot, and the slot.
    int          m_codes[$];
    bit          m_skip, m_pend, m_valid, m_started;
    logic [13:0] m_pend_vec, m_feat;
    int unsigned m_samples, m_drops;
    logic [7:0]  frame_data[16];

    function automatic int quant(input logic [7:0] x);
        return int'(x >= T1) + int'(x >= T2) + int'(x >= T3);
    endfunction

    function automatic logic [13:0] pack_codes();
        int v = 0;
        for (int i = 0; i < 7; i++) v += m_codes[i] * (4 ** i);
        return v[13:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_codes.delete();
        m_skip = 0; m_pend = 0; m_valid = 0; m_started = 0;
        m_pend_vec = '0; m_feat = '0;
        m_samples = 0; m_drops = 0;
    endtask

    // One clock cycle: drive, check in_ready, advance model, check outputs after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ordy, output bit acc);
        bit rdy, drain, copy, err;
        logic [13:0] vec;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        rdy = m_started && !m_pend;
        chk("in_ready", {15'd0, in_ready}, {15'd0, rdy});
        acc = v && rdy;
        drain = m_valid && ordy;
        copy = 0; err = 0; vec = '0;
        if (m_pend) begin
            if (drain) begin copy = 1; vec = m_pend_vec; m_pend = 0; end
        end else if (acc) begin
            if (m_skip) begin
                if (l) m_skip = 0;
            end else begin
                m_codes.push_back(quant(d));
                if (m_codes.size() == 7) begin
                    if (l) begin
                        vec = pack_codes();
                        m_codes.delete();
                        if (!m_valid || drain) copy = 1;
                        else begin m_pend = 1; m_pend_vec = vec; end
                    end else begin
                        err = 1; m_codes.delete(); m_skip = 1;
                    end
                end else if (l) begin
                    err = 1; m_codes.delete();
                end
            end
        end
        if (copy) begin m_valid = 1; m_feat = vec; m_samples++; end
        else if (drain) m_valid = 0;
        if (err) m_drops++;
        @(posedge clk); #1;
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        chk("frame_err", {15'd0, frame_err}, {15'd0, err});
        if (m_valid) chk("out_feat", {2'd0, out_feat}, {2'd0, m_feat});
`ifdef BC_FEATLOAD_STATS_EN
        chk("stat_samples", stat_samples, m_samples[15:0]);
        chk("stat_drops", stat_drops, m_drops[15:0]);
`endif
    endtask

    function automatic bit pick_ready(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return bit'(mode);
    endfunction

    // Present one beat until accepted; mode 0/1 = fixed out_ready, 2 = random.
    task automatic send_beat(input logic [7:0] d, input bit l, input int mode);
        bit acc = 0;
        for (int t = 0; t < 64 && !acc; t++) step(1'b1, d, l, pick_ready(mode), acc);
        if (!acc) begin
            n_checks++; n_fail++;
            $error("FAIL beat_timeout observed=not_accepted expected=accepted at %0t", $time);
        end
    endtask

    task automatic send_frame(input int len, input int mode, input bit gaps);
        bit acc;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 8'd0, 1'b0, pick_ready(mode), acc);
            send_beat(frame_data[i], i == len - 1, mode);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 16; i++) frame_data[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #3;
        model_reset();
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_feat", {2'd0, out_feat}, 16'd0);
        chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_started = 1;
    endtask

    initial begin
        bit acc;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Threshold boundaries with a ready consumer.
        frame_data[0] = 8'd0;   frame_data[1] = 8'd64;  frame_data[2] = 8'd127;
        frame_data[3] = 8'd128; frame_data[4] = 8'd191; frame_data[5] = 8'd192;
        frame_data[6] = 8'd255;
        send_frame(7, 1, 0);
        chk("t1_vec", {2'd0, out_feat}, {2'd0, 14'b11_11_10_10_01_01_00});
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // Two frames against a stalled consumer, then one-cycle drains.
        rand_data(); send_frame(7, 0, 0);
        rand_data(); send_frame(7, 0, 0);
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // Short frame, then a good one.
        rand_data(); send_frame(3, 0, 0);
        rand_data(); send_frame(7, 0, 0);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // Long frame swallowed, then a good one.
        rand_data(); send_frame(9, 1, 0);
        rand_data(); send_frame(7, 1, 0);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // Reset mid-frame, then a fresh frame.
        rand_data(); send_frame(4, 1, 0);
        do_reset();
        rand_data(); send_frame(7, 0, 0);
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // 3 good and 2 bad frames from reset for the counters.
        do_reset();
        for (int f = 0; f < 5; f++) begin
            rand_data();
            send_frame((f == 1) ? 2 : (f == 3) ? 8 : 7, 1, 0);
        end
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        // Random traffic: mixed lengths, idle gaps, random back-pressure.
        for (int f = 0; f < 60; f++) begin
            int lens[6] = '{7, 7, 7, 3, 9, 1};
            rand_data();
            send_frame(lens[$urandom_range(0, 5)], 2, 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bc_feature_loader.md
# bc_feature_loader

Upstream front-end for the 7-feature, 2-bit ternary-NN classifier core of the breast-cancer TNN flow. It accepts raw 8-bit feature samples one per beat over a valid/ready stream, quantises each to a 2-bit code, and assembles seven codes into one vector. Complete vectors are presented to the combinational classifier through a one-entry holding register with valid/ready handshake. Malformed frames are detected, dropped and flagged.

## Interface
- `T1`, default 8'd64: lowest quantisation threshold.
- `T2`, default 8'd128: middle threshold; must satisfy T1 < T2.
- `T3`, default 8'd192: highest threshold; must satisfy T2 < T3.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  raw feature beat valid.
- `in_ready`  out  1  loader accepts a beat this cycle.
- `in_data`  in  8  raw unsigned feature value.
- `in_last`  in  1  marks the 7th (final) beat of a sample.
- `out_valid`  out  1  `out_feat` holds a complete vector.
- `out_ready`  in  1  consumer takes the vector this cycle.
- `out_feat`  out  14  packed codes: [1:0] = feature 0 (input_a), [3:2] = feature 1 (input_b), and so on up to [13:12] = feature 6 (input_g).
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.

## Operation
- A beat transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Quantisation is combinational on in_data, with comparisons unsigned and inclusive:
  - code 3 if x >= T3
  - else code 2 if x >= T2
  - else code 1 if x >= T1
  - else code 0
- A 3-bit index `idx` (0..6) selects the collection slot. An accepted beat writes its code into slot idx.
- State machine:
  - COLLECT:
    - accepted beat with idx < 6 and !in_last: idx++.
    - accepted beat with idx < 6 and in_last: frame too short. Drop the sample, idx = 0, pulse frame_err, stay in COLLECT.
    - accepted beat with idx == 6 and in_last: sample complete. If the holding register is empty, or is being drained this same cycle, copy the collection into holding next edge, set idx = 0 and stay in COLLECT. Otherwise go to FULL.
    - accepted beat with idx == 6 and !in_last: frame too long. Drop the sample, pulse frame_err, idx = 0, go to DISCARD.
  - FULL: in_ready = 0. When holding drains (out_ready && out_valid), copy the collection into holding on that edge and return to COLLECT with idx = 0.
  - DISCARD: in_ready = 1 and beats are accepted but ignored. An accepted beat with in_last returns the machine to COLLECT with idx = 0. No further frame_err pulses.
- in_ready = 1 in COLLECT and DISCARD, 0 in FULL.
- Holding register: out_valid is set on a copy and cleared on drain with no new copy. A simultaneous drain and copy keeps out_valid = 1 with the new data.
- out_feat is stable whenever out_valid = 1 and out_ready = 0.
- Asynchronous reset mid-frame discards the partial sample and the holding contents.

## Timing
- Reset values: in_ready = 0 while rst_n is low and 1 from the first cycle after release; out_valid = 0; out_feat = 0; frame_err = 0; state COLLECT; idx = 0.
- Latency: out_valid rises on the edge that accepts the 7th beat, i.e. it is visible one cycle after that beat is presented.
- Throughput: one beat per cycle, sustained. Back-to-back samples need no bubble if the consumer drains each vector within 7 cycles.
- frame_err is asserted in the cycle following the offending beat, for exactly one cycle.

## Configuration
- `BC_FEATLOAD_STATS_EN`:
  - When defined, adds 16-bit output ports `stat_samples` (count of completed vectors copied to holding) and `stat_drops` (count of frame_err pulses).
  - Both counters reset to 0, wrap modulo 2^16 and increment in the cycle the event is registered.
  - When undefined, the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then beats 0, 64, 127, 128, 191, 192, 255 with in_last on the 7th and out_ready = 1 → out_valid one cycle after the 7th beat, out_feat = 14'b11_11_10_10_01_01_00, frame_err never asserted.
- Two back-to-back frames with out_ready = 0 → first vector held unchanged; after the second frame's 7th beat in_ready = 0 (state FULL). Raising out_ready for one cycle delivers vector 1, vector 2 appears on the next cycle, in_ready returns to 1.
- in_last on the 3rd beat → frame_err pulses once, out_valid stays 0, the next 7-beat frame is delivered correctly.
- 9-beat frame with in_last on beat 9 → one frame_err pulse after beat 7, beats 8–9 swallowed, the following good frame is delivered.
- rst_n pulsed low after 4 beats → out_valid = 0, idx = 0; a fresh 7-beat frame then produces exactly one vector.
- With BC_FEATLOAD_STATS_EN: 3 good frames and 2 bad frames → stat_samples = 3, stat_drops = 2.
